stereo_frame_packer: RTL
========================

# stereo_frame_packer

Upstream capture stage for the stereo matcher. It accepts two raster-order 8-bit grayscale pixel streams (left and right camera, 240 px wide × 320 rows) and packs each run of 6 horizontally adjacent pixels into one 48-bit word. It writes those words into the matcher's left/right frame BRAMs at word address `y*40 + x/6`. It raises the matcher's `new_frame_in` once both images are complete, then holds off new frames until the matcher reports it is done.

## Interface
Parameters:
- `IMG_W`, 240: pixels per row (x).
- `IMG_H`, 320: rows per frame (y).
- `PIX_PER_WORD`, 6: pixels packed per BRAM word; `IMG_W` must be a multiple.
- `WORDS`, `IMG_W/PIX_PER_WORD*IMG_H` = 12800: words per frame.

Ports:
- `clk_100mhz` in 1: single clock.
- `sys_rst` in 1: reset, synchronous, active-high.
- `left_valid_in` in 1: left pixel qualifier.
- `left_frame_start_in` in 1: marks the left pixel at (0,0); meaningful only with `left_valid_in`.
- `left_pixel_in` in 8: left pixel value.
- `right_valid_in`, `right_frame_start_in`, `right_pixel_in` in 1/1/8: the same three signals for the right stream.
- `match_done_in` in 1: one-cycle pulse from the matcher when disparity processing is finished.
- `left_we_out` out 1: left BRAM write enable, one cycle per word.
- `left_addr_out` out `$clog2(WORDS)` (14): left word address.
- `left_data_out` out 48: left packed word.
- `right_we_out`, `right_addr_out`, `right_data_out` out 1/14/48: the same three signals for the right BRAM.
- `writing_image_out` out 1: `left_we_out | right_we_out`; drives the matcher's BRAM address mux.
- `new_frame_out` out 1: one-cycle pulse when both frames are fully written.
- `dropped_frame_out` out 1: one-cycle pulse when a frame start is rejected.

## Operation
- Packing order: pixel with `x%6 == k` occupies `data[8k+7:8k]`, so pixel 0 is in the LSBs.
- Addresses are sequential in raster order. Each channel has its own word counter, 0..`WORDS-1`, incremented after each write.
- Each channel has its own sub-FSM:
  - C_IDLE:
    - Ignores pixels until `valid & frame_start`.
    - On that accepted start, the start pixel goes into lane 0; lane counter = 1, word counter = 0.
    - Moves to C_CAPTURE.
  - C_CAPTURE:
    - Each `valid` pixel goes into the current lane, and the lane counter advances.
    - On lane 5 the completed word (including the current pixel) is registered onto `*_data_out`/`*_addr_out` with `*_we_out = 1`.
    - Lane returns to 0; word counter increments.
    - After writing word `WORDS-1`, moves to C_DONE.
  - C_CAPTURE restart: `valid & frame_start` in C_CAPTURE discards the partial word and restarts at lane 0 / word 0 with this pixel as pixel (0,0). Words already written are not rewritten.
  - C_DONE: ignores all pixels, including frame starts.
- Top FSM:
  - ACCEPT (reset state):
    - Channels may capture.
    - When both channels are in C_DONE: pulse `new_frame_out`, go to WAIT_MATCH.
  - WAIT_MATCH:
    - Both channels are held in C_DONE.
    - Any `valid & frame_start` on either channel pulses `dropped_frame_out`; the pixel is ignored. If both channels start in the same cycle, a single pulse is issued.
    - On `match_done_in`: both channels go to C_IDLE, top goes to ACCEPT.
- `match_done_in` outside WAIT_MATCH is ignored.

## Timing
- Reset: all outputs 0. Top = ACCEPT, channels = C_IDLE, counters = 0.
- Reset asserted mid-frame aborts the frame with no further writes.
- Write latency: `*_we_out` is high in the cycle after the 6th pixel of a word is sampled. It is never high for two consecutive cycles, since at most 1 pixel/cycle is accepted.
- `*_addr_out` and `*_data_out` hold their last value when `*_we_out` is 0.
- Gaps in `valid` are allowed anywhere; the packer state holds.
- `new_frame_out` is asserted in the cycle after the later channel's final write. If both final writes occur in the same cycle, there is one pulse, one cycle later.
- If `frame_start` arrives in the same cycle as `match_done_in`, it is dropped and `dropped_frame_out` pulses. Acceptance begins the following cycle.
- The left and right streams are independent; arbitrary skew between them is allowed.

## Test plan
- Both streams start together with pixel = `(x+y)%256`:
  - Left writes addr 0 with data 48'h050403020100, one cycle after pixel 5.
  - Addr 12799 data = `{(239+319)%256 … (234+319)%256}` = 48'h2E2D2C2B2A29.
  - Exactly 12800 writes per channel.
  - One `new_frame_out` pulse, one cycle after the last write.
- Right stream lags left by 1000 cycles, with random `valid` gaps:
  - Packed words match the expected values exactly.
  - `new_frame_out` follows the right final write by one cycle.
  - `writing_image_out` equals the OR of the write enables throughout.
- After `new_frame_out`, drive a new frame start on both channels before `match_done_in`:
  - One `dropped_frame_out` pulse.
  - Zero writes.
  - After `match_done_in`, the next frame start is accepted and writes addr 0.
- Issue `frame_start` at left pixel (3,0) of a capturing frame:
  - No write from the partial word.
  - The next write is addr 0, containing the restarted pixels.
- Assert `sys_rst` for 1 cycle mid-frame (around word 5000):
  - All outputs 0 the next cycle.
  - Subsequent non-start pixels produce no writes until a new frame start.

Source files
------------

// File: rtl/stereo_frame_packer_if.sv
// Pixel-stream inputs and BRAM write-port outputs of the stereo frame packer.
// Pure signal bundle: no logic, no latency of its own.
// No backpressure: pixel streams are qualified by valid only.
interface stereo_frame_packer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 48
);
  logic              left_valid_in;
  logic              left_frame_start_in;
  logic [7:0]        left_pixel_in;
  logic              right_valid_in;
  logic              right_frame_start_in;
  logic [7:0]        right_pixel_in;
  logic              match_done_in;

  logic              left_we_out;
  logic [ADDR_W-1:0] left_addr_out;
  logic [DATA_W-1:0] left_data_out;
  logic              right_we_out;
  logic [ADDR_W-1:0] right_addr_out;
  logic [DATA_W-1:0] right_data_out;
  logic              writing_image_out;
  logic              new_frame_out;
  logic              dropped_frame_out;

  // Packer side: consumes pixels, drives the BRAM ports.
  modport slave (
    input  left_valid_in, left_frame_start_in, left_pixel_in,
    input  right_valid_in, right_frame_start_in, right_pixel_in,
    input  match_done_in,
    output left_we_out, left_addr_out, left_data_out,
    output right_we_out, right_addr_out, right_data_out,
    output writing_image_out, new_frame_out, dropped_frame_out
  );

  // Camera/matcher side: produces pixels, observes the BRAM ports.
  modport master (
    output left_valid_in, left_frame_start_in, left_pixel_in,
    output right_valid_in, right_frame_start_in, right_pixel_in,
    output match_done_in,
    input  left_we_out, left_addr_out, left_data_out,
    input  right_we_out, right_addr_out, right_data_out,
    input  writing_image_out, new_frame_out, dropped_frame_out
  );
endinterface

// File: rtl/stereo_frame_packer.sv
// Packs left/right raster pixel streams into PIX_PER_WORD-pixel words written to frame BRAMs.
// Latency: write enable one cycle after the last pixel of a word; new_frame one cycle after the later final write.
// No backpressure: at most one pixel per cycle per stream; frame starts while the matcher is busy are dropped.
module stereo_frame_packer #(
  parameter int IMG_W        = 240,
  parameter int IMG_H        = 320,
  parameter int PIX_PER_WORD = 6,
  parameter int WORDS        = IMG_W / PIX_PER_WORD * IMG_H
) (
  input  logic                   clk_100mhz,
  input  logic                   sys_rst,
  stereo_frame_packer_if.slave   bus
);
  localparam int ADDR_W = $clog2(WORDS);
  localparam int DATA_W = 8 * PIX_PER_WORD;
  localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {C_IDLE, C_CAPTURE, C_DONE} chan_state_t;
  typedef enum logic       {ACCEPT, WAIT_MATCH}        top_state_t;

  // Channel 0 is left, channel 1 is right.
  logic [1:0] ch_vld;
  logic [1:0] ch_start;
  logic [7:0] ch_pix [2];

  assign ch_vld   = {bus.right_valid_in, bus.left_valid_in};
  assign ch_start = {bus.right_frame_start_in, bus.left_frame_start_in};
  assign ch_pix[0] = bus.left_pixel_in;
  assign ch_pix[1] = bus.right_pixel_in;

  top_state_t        top_q, top_d;
  logic              new_frame_q, new_frame_d;
  logic              dropped_q, dropped_d;
  logic              release_frame;

  chan_state_t       cst_q  [2];
  chan_state_t       cst_d  [2];
  logic [LANE_W-1:0] lane_q [2];
  logic [LANE_W-1:0] lane_d [2];
  logic [ADDR_W-1:0] word_q [2];
  logic [ADDR_W-1:0] word_d [2];
  logic [DATA_W-1:0] acc_q  [2];
  logic [DATA_W-1:0] acc_d  [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [1:0]        we_q, we_d;

  // The matcher hands the buffers back only while we are waiting for it.
  assign release_frame = (top_q == WAIT_MATCH) && bus.match_done_in;

  // Top FSM: announce a complete stereo pair, then reject starts until the matcher is done.
  always_comb begin
    top_d       = top_q;
    new_frame_d = 1'b0;
    dropped_d   = 1'b0;
    case (top_q)
      ACCEPT: begin
        if (cst_q[0] == C_DONE && cst_q[1] == C_DONE) begin
          new_frame_d = 1'b1;
          top_d       = WAIT_MATCH;
        end
      end
      WAIT_MATCH: begin
        // Simultaneous starts on both channels collapse into one pulse.
        dropped_d = |(ch_vld & ch_start);
        if (bus.match_done_in) top_d = ACCEPT;
      end
      default: top_d = ACCEPT;
    endcase
  end

  // Channel FSMs: collect lanes, emit a word on the last lane, stop after the last word.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cst_d[c]  = cst_q[c];
      lane_d[c] = lane_q[c];
      word_d[c] = word_q[c];
      acc_d[c]  = acc_q[c];
      addr_d[c] = addr_q[c];
      data_d[c] = data_q[c];
      we_d[c]   = 1'b0;
      case (cst_q[c])
        C_IDLE, C_CAPTURE: begin
          if (ch_vld[c] && ch_start[c]) begin
            // A start always becomes pixel (0,0); any partial word is abandoned.
            acc_d[c]       = '0;
            acc_d[c][7:0]  = ch_pix[c];
            lane_d[c]      = LANE_W'(1);
            word_d[c]      = '0;
            cst_d[c]       = C_CAPTURE;
          end else if (ch_vld[c] && cst_q[c] == C_CAPTURE) begin
            if (lane_q[c] == LAST_LANE) begin
              data_d[c] = acc_q[c];
              data_d[c][DATA_W-1 -: 8] = ch_pix[c];
              addr_d[c] = word_q[c];
              we_d[c]   = 1'b1;
              lane_d[c] = '0;
              if (word_q[c] == LAST_WORD) begin
                word_d[c] = '0;
                cst_d[c]  = C_DONE;
              end else begin
                word_d[c] = word_q[c] + ADDR_W'(1);
              end
            end else begin
              acc_d[c][8*lane_q[c] +: 8] = ch_pix[c];
              lane_d[c] = lane_q[c] + LANE_W'(1);
            end
          end
        end
        C_DONE: begin
          if (release_frame) cst_d[c] = C_IDLE;
        end
        default: cst_d[c] = C_IDLE;
      endcase
    end
  end

  // Top state and status pulses.
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      top_q       <= ACCEPT;
      new_frame_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      top_q       <= top_d;
      new_frame_q <= new_frame_d;
      dropped_q   <= dropped_d;
    end
  end

  // Channel state, packing registers and BRAM write port.
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      for (int c = 0; c < 2; c++) begin
        cst_q[c]  <= C_IDLE;
        lane_q[c] <= '0;
        word_q[c] <= '0;
        acc_q[c]  <= '0;
        addr_q[c] <= '0;
        data_q[c] <= '0;
      end
      we_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        cst_q[c]  <= cst_d[c];
        lane_q[c] <= lane_d[c];
        word_q[c] <= word_d[c];
        acc_q[c]  <= acc_d[c];
        addr_q[c] <= addr_d[c];
        data_q[c] <= data_d[c];
      end
      we_q <= we_d;
    end
  end

  assign bus.left_we_out       = we_q[0];
  assign bus.left_addr_out     = addr_q[0];
  assign bus.left_data_out     = data_q[0];
  assign bus.right_we_out      = we_q[1];
  assign bus.right_addr_out    = addr_q[1];
  assign bus.right_data_out    = data_q[1];
  assign bus.writing_image_out = we_q[0] | we_q[1];
  assign bus.new_frame_out     = new_frame_q;
  assign bus.dropped_frame_out = dropped_q;
endmodule
